// File: rtl/sram_port_ctrl_if.sv
// Client-side request/response streams of sram_port_ctrl.
// master = datapath client, slave = the controller.
interface sram_port_ctrl_if #(
    parameter int BITS       = 39,
    parameter int ADDR_WIDTH = 11
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BITS-1:0]       req_wdata;
    logic [BITS-1:0]       req_wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [BITS-1:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_port_ctrl.sv
// Initiator-side port controller for one single-port fakeram macro.
// Turns a valid/ready request stream into legal SRAM cycles, returns read
// data in order through a small response FIFO, and optionally zero-fills
// the array after reset.
module sram_port_ctrl #(
    parameter int BITS          = 39,
    parameter int WORD_DEPTH    = 2048,
    parameter int ADDR_WIDTH    = 11,
    parameter int RSP_DEPTH     = 2,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_port_ctrl_if.slave       bus,
    output logic                  init_done,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    output logic [BITS-1:0]       sram_wmask,
    input  logic [BITS-1:0]       sram_rd
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(WORD_DEPTH - 1);
    localparam logic [CNT_W:0]      OCC_LIM   = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(RSP_DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                r_state;
    state_t                w_state_next;
    // One bit wider than the address so the last address compares cleanly.
    logic [ADDR_WIDTH:0]   r_init_cnt;
    logic                  r_inflight;
    logic [BITS-1:0]       r_fifo [RSP_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_rsp_valid;
    logic                  w_pop;
    logic                  w_req_ready;
    logic [CNT_W:0]        w_occ;
    logic                  w_ce;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [BITS-1:0]       w_wd;
    logic [BITS-1:0]       w_wmask;

    // Occupancy seen by the request side: stored entries plus the read whose
    // data lands next cycle, minus the entry leaving this cycle.
    assign w_rsp_valid = (r_count != '0);
    assign w_pop       = w_rsp_valid & bus.rsp_ready;
    assign w_occ       = {1'b0, r_count}
                       + {{CNT_W{1'b0}}, r_inflight}
                       - {{CNT_W{1'b0}}, w_pop};

    // State register; reset picks the sweep or goes straight to service.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            r_state <= INIT_ON_RESET ? ST_INIT : ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, request acceptance and SRAM pin drive.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch;
        // the zero defaults also keep the macro pins free of X when idle.
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_ce         = 1'b0;
        w_we         = 1'b0;
        w_addr       = '0;
        w_wd         = '0;
        w_wmask      = '0;
        if (!rst) begin
            case (r_state)
                ST_INIT: begin
                    w_ce    = 1'b1;
                    w_we    = 1'b1;
                    w_addr  = r_init_cnt[ADDR_WIDTH-1:0];
                    w_wmask = '1;
                    if (r_init_cnt == LAST_ADDR) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_req_ready = (w_occ < OCC_LIM);
                    if (bus.req_valid && w_req_ready) begin
                        w_ce    = 1'b1;
                        w_we    = bus.req_we;
                        w_addr  = bus.req_addr;
                        w_wd    = bus.req_wdata;
                        w_wmask = bus.req_wmask;
                    end
                end
                default: w_state_next = ST_RUN;
            endcase
        end
    end

    // Sweep counter, read-in-flight flag and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + (ADDR_WIDTH + 1)'(1);
            end
            r_inflight <= w_ce & ~w_we;
            if (r_inflight) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(r_inflight) - CNT_W'(w_pop);
        end
    end

    // Capture macro read data the cycle after a read was issued.
    always_ff @(posedge clk) begin
        // NOTE: the FIFO storage has no reset; validity comes from r_count,
        // so clearing the data words would only add reset fan-out.
        if (!rst && r_inflight) begin
            r_fifo[r_wr_ptr] <= sram_rd;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_fifo[r_rd_ptr];
    assign init_done     = (r_state == ST_RUN);
    assign sram_ce       = w_ce;
    assign sram_we       = w_we;
    assign sram_addr     = w_addr;
    assign sram_wd       = w_wd;
    assign sram_wmask    = w_wmask;
endmodule
